// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: result-mux select codes and
// the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_SLL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The requester that was
// not granted last wins a tie; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU datapath between two requesters: round-robin grant, operands
// held for EXEC_CYCLES, result captured and returned over a valid/ready channel.
//
//   state | meaning
//   IDLE  | arbitrating; ready asserted to the granted requester
//   EXEC  | operands/select held while the ALU settles; cnt counts down
//   RESP  | captured result presented until rsp_ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int CNT_W = 4;

  state_t             state, state_nxt;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  logic               idle;
  logic               accept;

  assign idle   = (state == IDLE);
  assign accept = |gnt;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (idle),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = EXEC;
      EXEC:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = idle && gnt[0];
    req1_ready = idle && gnt[1];
    busy       = (state == EXEC) || (state == RESP);
  end

  // Operand registers are only loaded on acceptance, so they keep their last
  // values through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_sel <= gnt[1] ? req1_op : req0_op;
            alu_a   <= gnt[1] ? req1_a  : req0_a;
            alu_b   <= gnt[1] ? req1_b  : req0_b;
            rsp_id  <= gnt[1];
            cnt     <= CNT_W'(EXEC_CYCLES - 1);
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: instance 0 uses EXEC_CYCLES=2,
// instance 1 uses EXEC_CYCLES=1; both share the requester/consumer stimulus.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  logic         r0_rdy [2];
  logic         r1_rdy [2];
  logic [W-1:0] alu_a_v [2];
  logic [W-1:0] alu_b_v [2];
  logic [2:0]   alu_sel_v [2];
  logic [W-1:0] alu_res [2];
  logic         rsp_valid_v [2];
  logic         rsp_id_v [2];
  logic [W-1:0] rsp_data_v [2];
  logic         busy_v [2];

  int checks = 0;
  int errors = 0;
  int vw = 0;
  int exec_n = 2;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_model(input logic [2:0] s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  return a << b[4:0];
      default: return '0;
    endcase
  endfunction

  assign alu_res[0] = alu_model(alu_sel_v[0], alu_a_v[0], alu_b_v[0]);
  assign alu_res[1] = alu_model(alu_sel_v[1], alu_a_v[1], alu_b_v[1]);

  alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_sel(alu_sel_v[0]),
    .alu_result(alu_res[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_v[0]),
    .rsp_data(rsp_data_v[0]), .busy(busy_v[0])
  );

  alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(1)) dut_e1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_sel(alu_sel_v[1]),
    .alu_result(alu_res[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_v[1]),
    .rsp_data(rsp_data_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge. Returns at the negedge where the response first shows.
  task automatic run_txn(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input string nm);
    int  n;
    bit  got;
    if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    got = 1'b0;
    for (n = 0; n < 20; n++) begin
      #1;
      if ((id == 0) ? r0_rdy[vw] : r1_rdy[vw]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({nm, " grant"}, W'(got), W'(1));
    if (!got) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    chk({nm, " wait"}, W'(n), W'(0));
    chk({nm, " other_ready"}, W'((id == 0) ? r1_rdy[vw] : r0_rdy[vw]), W'(0));
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    for (int k = 0; k < exec_n; k++) begin
      chk({nm, " sel_held"}, W'(alu_sel_v[vw]), W'(op));
      chk({nm, " a_held"}, alu_a_v[vw], a);
      chk({nm, " early_rsp"}, W'(rsp_valid_v[vw]), W'(0));
      chk({nm, " busy"}, W'(busy_v[vw]), W'(1));
      @(negedge clk);
    end
    chk({nm, " rsp_valid"}, W'(rsp_valid_v[vw]), W'(1));
    chk({nm, " rsp_data"}, rsp_data_v[vw], exp);
    chk({nm, " rsp_id"}, W'(rsp_id_v[vw]), W'(id));
  endtask

  typedef struct {
    int           id;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        nm;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  last_cyc;
    bit  got;

    tbl[0] = '{0, OP_ADD, 32'd5,          32'd3,          32'd8,          "add"};
    tbl[1] = '{1, OP_SUB, 32'd10,         32'd3,          32'd7,          "sub"};
    tbl[2] = '{0, OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  "and"};
    tbl[3] = '{1, OP_OR,  32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  "or"};
    tbl[4] = '{0, OP_XOR, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0,  "xor"};
    tbl[5] = '{1, OP_NOR, 32'h0000_0000,  32'hFFFF_0000,  32'h0000_FFFF,  "nor"};
    tbl[6] = '{0, OP_SLT, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0001,  "slt"};
    tbl[7] = '{1, OP_SLL, 32'h0000_0001,  32'h0000_0004,  32'h0000_0010,  "sll"};

    // reset values
    @(negedge clk);
    chk("rst alu_a", alu_a_v[0], '0);
    chk("rst alu_sel", W'(alu_sel_v[0]), '0);
    chk("rst rsp_valid", W'(rsp_valid_v[0]), '0);
    chk("rst rsp_data", rsp_data_v[0], '0);
    chk("rst busy", W'(busy_v[0]), '0);
    chk("rst ready0", W'(r0_rdy[0]), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // table of single-requester operations, back to back
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);
      @(negedge clk);
      chk({tbl[i].nm, " consumed"}, W'(rsp_valid_v[0]), W'(0));
      chk({tbl[i].nm, " idle"}, W'(busy_v[0]), W'(0));
    end

    // fairness from reset with both requesters continuously valid
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hF; req0_b = 32'h3;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hF; req1_b = 32'h3;
    last_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (r0_rdy[0] || r1_rdy[0]) begin got = 1'b1; break; end
        @(negedge clk);
      end
      chk("rr grant", W'(got), W'(1));
      chk("rr winner1", W'(r1_rdy[0]), W'(i % 2));
      chk("rr onehot", W'(r0_rdy[0] & r1_rdy[0]), W'(0));
      if (i > 0) chk("rr spacing", W'(cyc - last_cyc), W'(4));
      last_cyc = cyc;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk);

    // response backpressure, with a short-lived req0 pulse during RESP
    rsp_ready = 1'b0;
    run_txn(0, OP_SUB, 32'd10, 32'd3, 32'd7, "bp");
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'h0F; req1_b = 32'hF0;
    req0_valid = 1'b1; req0_op = OP_XOR;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp rsp_valid", W'(rsp_valid_v[0]), W'(1));
      chk("bp rsp_data", rsp_data_v[0], 32'd7);
      chk("bp rsp_id", W'(rsp_id_v[0]), W'(0));
      chk("bp ready0", W'(r0_rdy[0]), W'(0));
      chk("bp ready1", W'(r1_rdy[0]), W'(0));
      @(negedge clk);
      req0_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    run_txn(1, OP_OR, 32'h0F, 32'hF0, 32'hFF, "post_bp");
    @(negedge clk);

    // asynchronous reset in the middle of EXEC
    run_txn(0, OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, "pre_rst");
    @(negedge clk);
    req1_valid = 1'b1; req1_op = OP_NOR; req1_a = 32'h0; req1_b = 32'hFFFF_0000;
    #1;
    chk("mid ready1", W'(r1_rdy[0]), W'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    chk("mid busy", W'(busy_v[0]), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst alu_a", alu_a_v[0], '0);
    chk("arst alu_b", alu_b_v[0], '0);
    chk("arst alu_sel", W'(alu_sel_v[0]), '0);
    chk("arst rsp_valid", W'(rsp_valid_v[0]), '0);
    chk("arst rsp_data", rsp_data_v[0], '0);
    chk("arst rsp_id", W'(rsp_id_v[0]), '0);
    chk("arst busy", W'(busy_v[0]), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst no_rsp", W'(rsp_valid_v[0]), W'(0));
      chk("arst no_busy", W'(busy_v[0]), W'(0));
    end
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'h1; req1_b = 32'h2;
    run_txn(0, OP_XOR, 32'hFF, 32'h0F, 32'hF0, "after_rst");
    req1_valid = 1'b0;
    @(negedge clk);

    // EXEC_CYCLES = 1 instance
    vw = 1;
    exec_n = 1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1, OP_SLL, 32'd1, 32'd4, 32'd16, "e1");
    @(negedge clk);
    chk("e1 consumed", W'(rsp_valid_v[1]), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
